// File: rtl/traffic_light_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : traffic_light_monitor                                        |
// | Description : Watches the light codes of two lanes of a junction. It flags |
// |               conflicting greens, illegal light sequences, short yellows   |
// |               and, optionally, lights that stay unchanged for too long.    |
// |               It also counts red-to-green phase starts.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   MIN_YELLOW   minimum consecutive yellow samples per lane (>= 1)          |
// |   MAX_DWELL    watchdog limit, consecutive unchanged samples (>= 1)        |
// | Ports                                                                      |
// |   clk          clock, rising-edge active                                   |
// |   rst          asynchronous reset, active-low                              |
// |   la, lb       lane light codes: 00 green, 01 yellow, 10 red, 11 illegal   |
// |   err_clr      synchronous clear of all sticky flags (FAULT -> INIT)       |
// |   err_conflict sticky: both lanes non-red in the same sample               |
// |   err_seq      sticky: illegal transition or illegal code                  |
// |   err_yellow   sticky: yellow held for fewer than MIN_YELLOW samples       |
// |   err_stuck    sticky: a lane unchanged for MAX_DWELL samples              |
// |   phase_cnt    number of red-to-green transitions, modulo 256              |
// |   fault        high while the monitor is in FAULT                          |
// | Build option                                                               |
// |   TL_MON_WDOG_EN  when defined, builds the per-lane dwell watchdog; when   |
// |                   undefined, err_stuck is tied to 0                        |
// +----------------------------------------------------------------------------+
module traffic_light_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DWELL  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] la,
  input  logic [1:0] lb,
  input  logic       err_clr,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       err_yellow,
  output logic       err_stuck,
  output logic [7:0] phase_cnt,
  output logic       fault
);

  localparam logic [1:0] C_GREEN  = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;
  localparam int         YW       = $clog2(MIN_YELLOW + 1);

  // Zero or negative limits make the checks meaningless; stop elaboration.
  if (MIN_YELLOW < 1 || MAX_DWELL < 1) begin : g_param_check
    $error("traffic_light_monitor: MIN_YELLOW and MAX_DWELL must be >= 1");
  end

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    prev_a_q, prev_b_q;
  logic [YW-1:0] ycnt_a_q, ycnt_a_d;
  logic [YW-1:0] ycnt_b_q, ycnt_b_d;
  logic          conflict_q, conflict_d;
  logic          seq_q, seq_d;
  logic          yellow_q, yellow_d;
  logic [7:0]    phase_q, phase_d;

  logic          chk_trans;
  logic          chk_conf;
  logic          new_conflict;
  logic          new_seq;
  logic          new_yellow;
  logic          new_stuck;
  logic          any_err;
  logic          rg_a, rg_b;

  // Legal per-lane steps: hold any proper colour, or advance G->Y->R->G.
  function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
    logic ok;
    case ({p, c})
      {C_GREEN,  C_GREEN },
      {C_GREEN,  C_YELLOW},
      {C_YELLOW, C_YELLOW},
      {C_YELLOW, C_RED   },
      {C_RED,    C_RED   },
      {C_RED,    C_GREEN }: ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Consecutive-yellow counter; saturating keeps it narrow since only
  // "reached MIN_YELLOW or not" matters.
  function automatic logic [YW-1:0] yel_next(input logic [1:0] c, input logic [YW-1:0] cnt);
    logic [YW-1:0] n;
    if (c != C_YELLOW) begin
      n = '0;
    end else if (cnt == YW'(MIN_YELLOW)) begin
      n = cnt;
    end else begin
      n = cnt + YW'(1);
    end
    return n;
  endfunction

  always_comb begin
    // INIT only captures history; conflicts are not re-checked in FAULT.
    chk_trans    = (state_q != S_INIT);
    chk_conf     = (state_q != S_FAULT);

    new_conflict = chk_conf && (la != C_RED) && (lb != C_RED);
    new_seq      = chk_trans && (!legal_step(prev_a_q, la) || !legal_step(prev_b_q, lb));
    // The yellow count still holds the run that ended on the previous sample.
    new_yellow   = chk_trans &&
                   (((prev_a_q == C_YELLOW) && (la == C_RED) && (ycnt_a_q < YW'(MIN_YELLOW))) ||
                    ((prev_b_q == C_YELLOW) && (lb == C_RED) && (ycnt_b_q < YW'(MIN_YELLOW))));
    rg_a         = chk_trans && (prev_a_q == C_RED) && (la == C_GREEN);
    rg_b         = chk_trans && (prev_b_q == C_RED) && (lb == C_GREEN);

    any_err      = new_conflict | new_seq | new_yellow | new_stuck;

    ycnt_a_d     = yel_next(la, ycnt_a_q);
    ycnt_b_d     = yel_next(lb, ycnt_b_q);
    phase_d      = phase_q + 8'(rg_a) + 8'(rg_b);

    // A fresh error in the same cycle as err_clr keeps its flag set.
    conflict_d   = (conflict_q & ~err_clr) | new_conflict;
    seq_d        = (seq_q      & ~err_clr) | new_seq;
    yellow_d     = (yellow_q   & ~err_clr) | new_yellow;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = any_err ? S_FAULT : S_RUN;
      S_RUN:   if (any_err) state_d = S_FAULT;
      S_FAULT: if (err_clr && !any_err) state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      prev_a_q   <= C_RED;
      prev_b_q   <= C_RED;
      ycnt_a_q   <= '0;
      ycnt_b_q   <= '0;
      conflict_q <= 1'b0;
      seq_q      <= 1'b0;
      yellow_q   <= 1'b0;
      phase_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_a_q   <= la;
      prev_b_q   <= lb;
      ycnt_a_q   <= ycnt_a_d;
      ycnt_b_q   <= ycnt_b_d;
      conflict_q <= conflict_d;
      seq_q      <= seq_d;
      yellow_q   <= yellow_d;
      phase_q    <= phase_d;
    end
  end

`ifdef TL_MON_WDOG_EN
  localparam int DW = $clog2(MAX_DWELL + 1);

  logic [DW-1:0] dwell_a_q, dwell_a_d;
  logic [DW-1:0] dwell_b_q, dwell_b_d;
  logic          stuck_q, stuck_d;
  logic          same_a, same_b;

  // Dwell counts samples equal to their predecessor. It saturates at the
  // limit and the flag fires only on the step that reaches it, so a cleared
  // flag stays clear until the lane changes and stalls again.
  always_comb begin
    same_a    = (la == prev_a_q);
    same_b    = (lb == prev_b_q);
    dwell_a_d = !same_a ? '0 : (dwell_a_q == DW'(MAX_DWELL)) ? dwell_a_q : dwell_a_q + DW'(1);
    dwell_b_d = !same_b ? '0 : (dwell_b_q == DW'(MAX_DWELL)) ? dwell_b_q : dwell_b_q + DW'(1);
    new_stuck = (same_a && (dwell_a_q == DW'(MAX_DWELL - 1))) ||
                (same_b && (dwell_b_q == DW'(MAX_DWELL - 1)));
    stuck_d   = (stuck_q & ~err_clr) | new_stuck;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_a_q <= '0;
      dwell_b_q <= '0;
      stuck_q   <= 1'b0;
    end else begin
      dwell_a_q <= dwell_a_d;
      dwell_b_q <= dwell_b_d;
      stuck_q   <= stuck_d;
    end
  end

  assign err_stuck = stuck_q;
`else
  assign new_stuck = 1'b0;
  assign err_stuck = 1'b0;
`endif

  assign err_conflict = conflict_q;
  assign err_seq      = seq_q;
  assign err_yellow   = yellow_q;
  assign phase_cnt    = phase_q;
  assign fault        = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_traffic_light_monitor                                     |
// | Description : Self-checking bench for traffic_light_monitor. A reference   |
// |               model tracks lane history with plain integers and a per-     |
// |               cycle compare process checks every output; directed          |
// |               sequences pin known values. Build with TL_MON_WDOG_EN to     |
// |               exercise the watchdog.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_traffic_light_monitor;

  localparam int MIN_YELLOW = 2;
  localparam int MAX_DWELL  = 16;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] la, lb;
  logic       err_clr;
  logic       err_conflict, err_seq, err_yellow, err_stuck, fault;
  logic [7:0] phase_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_DWELL (MAX_DWELL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .la          (la),
    .lb          (lb),
    .err_clr     (err_clr),
    .err_conflict(err_conflict),
    .err_seq     (err_seq),
    .err_yellow  (err_yellow),
    .err_stuck   (err_stuck),
    .phase_cnt   (phase_cnt),
    .fault       (fault)
  );

  // ---------------- reference model ----------------
  bit m_armed;              // next sample gets transition checks
  bit m_fault;
  bit m_conf, m_seq, m_yel, m_stuck;
  int m_phase;
  int m_prev_a, m_prev_b;
  int m_yrun_a, m_yrun_b;   // length of current yellow run
  int m_same_a, m_same_b;   // samples equal to their predecessor, in a row

  // Colours cycle 0 -> 1 -> 2 -> 0; holding is allowed; code 3 never is.
  function automatic bit legal(input int p, input int c);
    return (c != 3) && (p != 3) && ((p == c) || (c == (p + 1) % 3));
  endfunction

  task automatic model_reset();
    m_armed = 0; m_fault = 0;
    m_conf = 0; m_seq = 0; m_yel = 0; m_stuck = 0;
    m_phase = 0;
    m_prev_a = 2; m_prev_b = 2;
    m_yrun_a = 0; m_yrun_b = 0;
    m_same_a = 0; m_same_b = 0;
  endtask

  task automatic model_step(input int a, input int b, input bit clr);
    bit conf, seq, yel, stuck;
    int rg;
    conf = 0; seq = 0; yel = 0; stuck = 0; rg = 0;
    if (!m_fault && a != 2 && b != 2) conf = 1;
    if (m_armed) begin
      seq = !legal(m_prev_a, a) || !legal(m_prev_b, b);
      yel = (m_prev_a == 1 && a == 2 && m_yrun_a < MIN_YELLOW) ||
            (m_prev_b == 1 && b == 2 && m_yrun_b < MIN_YELLOW);
      rg  = int'(m_prev_a == 2 && a == 0) + int'(m_prev_b == 2 && b == 0);
    end
    m_same_a = (a == m_prev_a) ? m_same_a + 1 : 0;
    m_same_b = (b == m_prev_b) ? m_same_b + 1 : 0;
`ifdef TL_MON_WDOG_EN
    stuck = (m_same_a == MAX_DWELL) || (m_same_b == MAX_DWELL);
`endif
    m_yrun_a = (a == 1) ? m_yrun_a + 1 : 0;
    m_yrun_b = (b == 1) ? m_yrun_b + 1 : 0;
    m_conf  = (m_conf  && !clr) || conf;
    m_seq   = (m_seq   && !clr) || seq;
    m_yel   = (m_yel   && !clr) || yel;
    m_stuck = (m_stuck && !clr) || stuck;
    if (conf || seq || yel || stuck) begin
      m_fault = 1; m_armed = 1;
    end else if (m_fault) begin
      if (clr) begin m_fault = 0; m_armed = 0; end
    end else begin
      m_armed = 1;
    end
    m_phase  = (m_phase + rg) % 256;
    m_prev_a = a;
    m_prev_b = b;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("err_conflict", 8'(err_conflict), 8'(m_conf));
      chk("err_seq",      8'(err_seq),      8'(m_seq));
      chk("err_yellow",   8'(err_yellow),   8'(m_yel));
      chk("err_stuck",    8'(err_stuck),    8'(m_stuck));
      chk("fault",        8'(fault),        8'(m_fault));
      chk("phase_cnt",    phase_cnt,        8'(m_phase));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [1:0] a, input logic [1:0] b, input bit clr);
    la = a; lb = b; err_clr = clr;
    @(posedge clk);
    if (rst) model_step(int'(a), int'(b), clr);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] p);
    int r;
    logic [1:0] n;
    r = $urandom_range(0, 99);
    if (r < 8)       n = 2'($urandom_range(0, 3));
    else if (r < 55) n = p;
    else begin
      case (p)
        G:       n = Y;
        Y:       n = R;
        R:       n = G;
        default: n = R;
      endcase
    end
    return n;
  endfunction

  logic [1:0] ca, cb;

  initial begin
    rst = 1'b0; la = R; lb = R; err_clr = 1'b0;
    do_reset();
    check_en = 1'b1;
    chk("reset_fault", 8'(fault), 8'd0);
    chk("reset_phase", phase_cnt, 8'd0);

    // Clean sequence on A, B red throughout.
    step(G, R, 0); step(G, R, 0); step(Y, R, 0); step(Y, R, 0); step(R, R, 0);
    chk("seqA_flags", 8'({err_conflict, err_seq, err_yellow}), 8'd0);
    chk("seqA_fault", 8'(fault), 8'd0);
    chk("seqA_phase", phase_cnt, 8'd0);

    // Conflict, then clear returns to INIT.
    do_reset();
    step(R, Y, 0);
    step(G, Y, 0);
    chk("conflict_flag",  8'(err_conflict), 8'd1);
    chk("conflict_fault", 8'(fault),        8'd1);
    step(G, R, 1);
    chk("clr_conflict", 8'(err_conflict), 8'd0);
    chk("clr_fault",    8'(fault),        8'd0);
    chk("clr_phase",    phase_cnt,        8'd1);
    step(R, R, 0);   // G->R would be illegal if checked; INIT must not check
    chk("init_nocheck", 8'(err_seq), 8'd0);

    // Illegal transitions.
    do_reset();
    step(G, R, 0); step(R, R, 0);
    chk("seq_GR",       8'(err_seq), 8'd1);
    chk("seq_GR_fault", 8'(fault),   8'd1);
    do_reset();
    step(X, R, 0);
    chk("seq_11_init", 8'(err_seq), 8'd0);
    step(X, R, 0);
    chk("seq_11_run", 8'(err_seq), 8'd1);

    // Short and adequate yellow.
    do_reset();
    step(G, R, 0); step(Y, R, 0); step(R, R, 0);
    chk("yellow_short", 8'(err_yellow), 8'd1);
    do_reset();
    step(G, R, 0); step(Y, R, 0); step(Y, R, 0); step(R, R, 0);
    chk("yellow_ok",       8'(err_yellow), 8'd0);
    chk("yellow_ok_fault", 8'(fault),      8'd0);

    // Phase counter wrap, then asynchronous reset mid-count.
    do_reset();
    step(R, R, 0);
    for (int i = 0; i < 256; i++) begin
      step(G, R, 0); step(Y, R, 0); step(Y, R, 0); step(R, R, 0);
      if (i == 254) chk("phase_255", phase_cnt, 8'd255);
    end
    chk("phase_wrap", phase_cnt, 8'd0);
    step(G, R, 0); step(Y, R, 0); step(Y, R, 0); step(R, R, 0); step(G, R, 0);
    chk("phase_2", phase_cnt, 8'd2);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_phase", phase_cnt, 8'd0);
    chk("async_fault", 8'(fault), 8'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Watchdog: lanes held red from reset.
    do_reset();
    for (int i = 0; i < MAX_DWELL - 1; i++) step(R, R, 0);
    chk("stuck_15", 8'(err_stuck), 8'd0);
    step(R, R, 0);
`ifdef TL_MON_WDOG_EN
    chk("stuck_16", 8'(err_stuck), 8'd1);
`else
    chk("stuck_16", 8'(err_stuck), 8'd0);
`endif

    // Randomized walk with occasional clears and resets.
    do_reset();
    ca = R; cb = R;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        ca = R; cb = R;
      end
      ca = nxt(ca);
      cb = nxt(cb);
      step(ca, cb, $urandom_range(0, 9) == 0);
    end

    step(R, R, 0);
    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter MIN_YELLOW, default 2, giving the minimum consecutive yellow samples per lane.
REQ-002 The block SHALL have parameter MAX_DWELL, default 16, giving the watchdog dwell limit in samples.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port la, input, 2 bits: lane A light code (00 green, 01 yellow, 10 red, 11 illegal).
REQ-006 The block SHALL have port lb, input, 2 bits: lane B light code, same encoding as la.
REQ-007 The block SHALL have port err_clr, input, 1 bit: synchronous clear of all sticky error flags.
REQ-008 The block SHALL have port err_conflict, output, 1 bit: sticky flag, both lanes non-red.
REQ-009 The block SHALL have port err_seq, output, 1 bit: sticky flag, illegal transition or illegal code.
REQ-010 The block SHALL have port err_yellow, output, 1 bit: sticky flag, yellow shorter than MIN_YELLOW.
REQ-011 The block SHALL have port err_stuck, output, 1 bit: sticky watchdog flag.
REQ-012 The block SHALL have port phase_cnt, output, 8 bits: count of red-to-green transitions on either lane.
REQ-013 The block SHALL have port fault, output, 1 bit: high while the FSM is in FAULT.

Function
REQ-014 The block SHALL sample la/lb on every rising edge; flags SHALL update on that same edge, visible one cycle after the offending sample is presented.
REQ-015 The FSM SHALL have states INIT, RUN and FAULT; INIT SHALL capture la/lb as previous values without checking and SHALL move to RUN.
REQ-016 In RUN, the legal per-lane transitions SHALL be G->G, G->Y, Y->Y, Y->R, R->R, R->G; any other transition or code 11 SHALL set err_seq.
REQ-017 In INIT or RUN, a sample with la!=10 and lb!=10 SHALL set err_conflict.
REQ-018 A per-lane yellow counter SHALL count consecutive yellow samples, saturating at MIN_YELLOW; a Y->R transition with count < MIN_YELLOW SHALL set err_yellow.
REQ-019 Each R->G transition SHALL increment phase_cnt by 1; simultaneous R->G on both lanes SHALL add 2; 255 SHALL wrap to 0 (mod 256).
REQ-020 Any error set SHALL move RUN to FAULT; in FAULT, checks SHALL continue and further flags SHALL accumulate.
REQ-021 err_clr SHALL clear all four flags and move FAULT to INIT; phase_cnt SHALL be unaffected.
REQ-022 When err_clr coincides with a new error, set SHALL win: the flag stays 1 and the FSM stays in or enters FAULT.

Reset
REQ-023 rst low SHALL asynchronously force state INIT, all flags 0, phase_cnt 0, fault 0 and all counters and previous-sample registers to red/0.
REQ-024 Reset asserted mid-sequence SHALL discard history; the first sample after release SHALL be INIT-captured and not transition-checked.

Configuration
REQ-025 With TL_MON_WDOG_EN defined, a per-lane dwell counter SHALL count consecutive unchanged samples, reset on any change, and set err_stuck when either lane reaches MAX_DWELL.
REQ-026 With TL_MON_WDOG_EN undefined, err_stuck SHALL remain a port tied to 0 and no dwell counters SHALL be built.

Verification
REQ-027 Sequence A: G,G,Y,Y,R with B red throughout -> no flags set, phase_cnt unchanged, fault 0.
REQ-028 la=00 and lb=01 for one sample -> err_conflict=1 and fault=1 next cycle; err_clr pulse -> both 0, FSM in INIT.
REQ-029 A: G->R directly -> err_seq=1; la=11 from reset -> err_seq=1 after the first RUN sample.
REQ-030 A: Y for 1 sample then R (MIN_YELLOW=2) -> err_yellow=1; Y for 2 samples then R -> no flag.
REQ-031 256 R->G cycles on A -> phase_cnt=0 (wrap); rst pulsed low mid-count -> phase_cnt=0 immediately, before the next clock edge.
REQ-032 With TL_MON_WDOG_EN defined, A held red for 16 samples -> err_stuck=1; with the macro undefined, err_stuck stays 0.
